// File: rtl/weight_alloc_engine.sv
// weight_alloc_engine
//   Fault-aware weight-row allocator. A table of faulty physical rows (row
//   address + faulty-PE mask) is loaded while idle. During a run each
//   incoming weight row is placed on the unassigned faulty row whose faulty
//   PEs it fully covers with zero weights. The largest mask wins, and ties go
//   to the lowest entry. Without such a row, the weight row goes to the lowest
//   free healthy row. One registered mapping record is emitted per weight row,
//   followed by a run summary.
//
//   Optional feature: define WA_HIT_CNT_EN to build the faulty-row placement
//   counter driving hit_cnt. Otherwise hit_cnt is tied to zero.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     flt_wr_en/idx/row/mask   fault-table write (idle only, mask==0 invalidates)
//     start                    begin a run (idle only)
//     w_valid/w_ready/w_last   weight-row stream handshake, w_row = row data
//     map_valid/map_ready      mapping-record handshake
//     map_widx/prow/fhit/fail  mapping record fields
//     busy, done               not idle / one-cycle end-of-run pulse
//     success, recov_all       run summary, held until the next start
//     hit_cnt                  faulty-row placements in the current run
module weight_alloc_engine #(
  parameter int ARRAY_SIZE        = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int NUM_FAULT_ENTRIES = 4,
  parameter int NUM_WEIGHT_ROWS   = 8,
  localparam int ROW_AW  = $clog2(ARRAY_SIZE),
  localparam int FE_AW   = $clog2(NUM_FAULT_ENTRIES),
  localparam int WIDX_AW = $clog2(NUM_WEIGHT_ROWS + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flt_wr_en,
  input  logic [FE_AW-1:0]                   flt_wr_idx,
  input  logic [ROW_AW-1:0]                  flt_wr_row,
  input  logic [ARRAY_SIZE-1:0]              flt_wr_mask,
  input  logic                               start,
  input  logic                               w_valid,
  output logic                               w_ready,
  input  logic                               w_last,
  input  logic [ARRAY_SIZE*WEIGHT_WIDTH-1:0] w_row,
  output logic                               map_valid,
  input  logic                               map_ready,
  output logic [WIDX_AW-1:0]                 map_widx,
  output logic [ROW_AW-1:0]                  map_prow,
  output logic                               map_fhit,
  output logic                               map_fail,
  output logic                               busy,
  output logic                               done,
  output logic                               success,
  output logic                               recov_all,
  output logic [WIDX_AW-1:0]                 hit_cnt
);

  localparam int PC_W = $clog2(ARRAY_SIZE + 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_CHECK, S_DONE} state_t;

  state_t                   state;
  logic [ROW_AW-1:0]        flt_row  [NUM_FAULT_ENTRIES];
  logic [ARRAY_SIZE-1:0]    flt_mask [NUM_FAULT_ENTRIES];
  logic [NUM_FAULT_ENTRIES-1:0] flt_vld;
  logic [NUM_FAULT_ENTRIES-1:0] recov;
  logic [ARRAY_SIZE-1:0]    used;
  logic [WIDX_AW-1:0]       widx;
  logic                     fail_seen;

  logic                     w_acc;
  logic [ARRAY_SIZE-1:0]    zmask;
  logic [ARRAY_SIZE-1:0]    faulty_rows;
  logic                     win_found;
  logic [FE_AW-1:0]         win_idx;
  logic [PC_W-1:0]          win_pc;
  logic [PC_W-1:0]          pc_tmp;
  logic                     cand_tmp;
  logic                     free_found;
  logic [ROW_AW-1:0]        free_row;

  assign w_ready = (state == S_RUN) && (!map_valid || map_ready);
  assign w_acc   = w_valid && w_ready;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_comb begin
    flt_vld = '0;
    for (int unsigned e = 0; e < NUM_FAULT_ENTRIES; e++)
      flt_vld[e] = |flt_mask[e];
  end

  always_comb begin
    zmask = '0;
    for (int unsigned j = 0; j < ARRAY_SIZE; j++)
      zmask[j] = (w_row[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0);
  end

  // Faulty-row winner: strict '>' while scanning upward keeps the lowest
  // entry on popcount ties.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pc    = '0;
    pc_tmp    = '0;
    cand_tmp  = 1'b0;
    for (int unsigned e = 0; e < NUM_FAULT_ENTRIES; e++) begin
      pc_tmp = '0;
      for (int unsigned j = 0; j < ARRAY_SIZE; j++)
        pc_tmp = pc_tmp + PC_W'(flt_mask[e][j]);
      cand_tmp = flt_vld[e] && !recov[e] && !used[flt_row[e]] &&
                 ((flt_mask[e] & ~zmask) == '0);
      if (cand_tmp && (!win_found || pc_tmp > win_pc)) begin
        win_found = 1'b1;
        win_idx   = FE_AW'(e);
        win_pc    = pc_tmp;
      end
    end
  end

  // Healthy fallback: rows named by any valid entry are never handed out as
  // healthy, even once that entry has been consumed.
  always_comb begin
    faulty_rows = '0;
    for (int unsigned e = 0; e < NUM_FAULT_ENTRIES; e++)
      if (flt_vld[e]) faulty_rows[flt_row[e]] = 1'b1;
    free_found = 1'b0;
    free_row   = '0;
    for (int unsigned r = 0; r < ARRAY_SIZE; r++) begin
      if (!free_found && !used[r] && !faulty_rows[r]) begin
        free_found = 1'b1;
        free_row   = ROW_AW'(r);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      for (int unsigned e = 0; e < NUM_FAULT_ENTRIES; e++) begin
        flt_row[e]  <= '0;
        flt_mask[e] <= '0;
      end
      recov     <= '0;
      used      <= '0;
      widx      <= '0;
      fail_seen <= 1'b0;
      success   <= 1'b0;
      recov_all <= 1'b0;
      map_valid <= 1'b0;
      map_widx  <= '0;
      map_prow  <= '0;
      map_fhit  <= 1'b0;
      map_fail  <= 1'b0;
    end else begin
      // A new accept below overrides this clear in the same cycle.
      if (map_valid && map_ready) map_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flt_wr_en) begin
            flt_row[flt_wr_idx]  <= flt_wr_row;
            flt_mask[flt_wr_idx] <= flt_wr_mask;
          end
          if (start) begin
            state     <= S_RUN;
            used      <= '0;
            recov     <= '0;
            widx      <= '0;
            fail_seen <= 1'b0;
            success   <= 1'b0;
            recov_all <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_acc) begin
            map_valid <= 1'b1;
            map_widx  <= widx;
            widx      <= widx + 1'b1;
            if (win_found) begin
              map_prow                <= flt_row[win_idx];
              map_fhit                <= 1'b1;
              map_fail                <= 1'b0;
              recov[win_idx]          <= 1'b1;
              used[flt_row[win_idx]]  <= 1'b1;
            end else if (free_found) begin
              map_prow       <= free_row;
              map_fhit       <= 1'b0;
              map_fail       <= 1'b0;
              used[free_row] <= 1'b1;
            end else begin
              map_prow  <= '0;
              map_fhit  <= 1'b0;
              map_fail  <= 1'b1;
              fail_seen <= 1'b1;
            end
            if (w_last || widx == WIDX_AW'(NUM_WEIGHT_ROWS - 1))
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!map_valid) state <= S_CHECK;
        end
        S_CHECK: begin
          success   <= !fail_seen;
          recov_all <= &(recov | ~flt_vld);
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WA_HIT_CNT_EN
  logic [WIDX_AW-1:0] hit_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q <= '0;
    end else if (state == S_IDLE && start) begin
      hit_cnt_q <= '0;
    end else if (w_acc && win_found && hit_cnt_q != WIDX_AW'(NUM_WEIGHT_ROWS)) begin
      hit_cnt_q <= hit_cnt_q + 1'b1;
    end
  end

  assign hit_cnt = hit_cnt_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_weight_alloc_engine.sv
// Self-checking bench for weight_alloc_engine: directed scenarios plus
// randomized runs against a behavioural allocation model.
module tb_weight_alloc_engine;

  localparam int AS      = 8;
  localparam int WW      = 8;
  localparam int NFE     = 4;
  localparam int NWR     = 8;
  localparam int ROW_AW  = $clog2(AS);
  localparam int FE_AW   = $clog2(NFE);
  localparam int WIDX_AW = $clog2(NWR + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flt_wr_en = 1'b0;
  logic [FE_AW-1:0]      flt_wr_idx = '0;
  logic [ROW_AW-1:0]     flt_wr_row = '0;
  logic [AS-1:0]         flt_wr_mask = '0;
  logic                  start = 1'b0;
  logic                  w_valid = 1'b0;
  logic                  w_ready;
  logic                  w_last = 1'b0;
  logic [AS*WW-1:0]      w_row = '0;
  logic                  map_valid;
  logic                  map_ready = 1'b1;
  logic [WIDX_AW-1:0]    map_widx;
  logic [ROW_AW-1:0]     map_prow;
  logic                  map_fhit;
  logic                  map_fail;
  logic                  busy;
  logic                  done;
  logic                  success;
  logic                  recov_all;
  logic [WIDX_AW-1:0]    hit_cnt;

  always #5 clk = ~clk;

  weight_alloc_engine #(
    .ARRAY_SIZE(AS),
    .WEIGHT_WIDTH(WW),
    .NUM_FAULT_ENTRIES(NFE),
    .NUM_WEIGHT_ROWS(NWR)
  ) dut (
    .clk(clk), .rst(rst),
    .flt_wr_en(flt_wr_en), .flt_wr_idx(flt_wr_idx), .flt_wr_row(flt_wr_row),
    .flt_wr_mask(flt_wr_mask), .start(start),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_row(w_row),
    .map_valid(map_valid), .map_ready(map_ready), .map_widx(map_widx),
    .map_prow(map_prow), .map_fhit(map_fhit), .map_fail(map_fail),
    .busy(busy), .done(done), .success(success), .recov_all(recov_all),
    .hit_cnt(hit_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int widx; int prow; bit fhit; bit fail; } rec_t;

  int            m_row  [NFE];
  logic [AS-1:0] m_mask [NFE];
  bit            m_used [AS];
  bit            m_recov[NFE];
  int            m_widx;
  bit            m_any_fail;
  int            m_hits;
  bit            m_run;

  rec_t             exp_q[$];
  rec_t             got_q[$];
  logic [AS*WW-1:0] wq[$];
  bit               d_success, d_recov;
  int               d_hit;
  int               hold_left;

  task automatic model_reset();
    for (int e = 0; e < NFE; e++) begin m_row[e] = 0; m_mask[e] = '0; m_recov[e] = 0; end
    for (int r = 0; r < AS; r++) m_used[r] = 0;
    m_widx = 0; m_any_fail = 0; m_hits = 0; m_run = 0;
    exp_q.delete();
  endtask

  task automatic model_write(input int idx, input int row, input logic [AS-1:0] mask);
    m_row[idx]  = row;
    m_mask[idx] = mask;
  endtask

  task automatic model_start();
    for (int e = 0; e < NFE; e++) m_recov[e] = 0;
    for (int r = 0; r < AS; r++) m_used[r] = 0;
    m_widx = 0; m_any_fail = 0; m_hits = 0; m_run = 1;
  endtask

  task automatic model_accept(input logic [AS*WW-1:0] row, input bit last, output rec_t r);
    logic [AS-1:0] zero_cols;
    int best;
    bit in_table;
    for (int j = 0; j < AS; j++) zero_cols[j] = (row[j*WW +: WW] == '0);
    r.widx = m_widx; r.prow = 0; r.fhit = 0; r.fail = 0;
    best = -1;
    for (int e = 0; e < NFE; e++) begin
      if (m_mask[e] == '0 || m_recov[e] || m_used[m_row[e]]) continue;
      if ((m_mask[e] & zero_cols) != m_mask[e]) continue;
      if (best < 0 || $countones(m_mask[e]) > $countones(m_mask[best])) best = e;
    end
    if (best >= 0) begin
      r.prow = m_row[best]; r.fhit = 1;
      m_recov[best] = 1; m_used[m_row[best]] = 1; m_hits++;
    end else begin
      r.fail = 1;
      for (int p = 0; p < AS; p++) begin
        in_table = 0;
        for (int e = 0; e < NFE; e++)
          if (m_mask[e] != '0 && m_row[e] == p) in_table = 1;
        if (!m_used[p] && !in_table) begin
          r.prow = p; r.fail = 0; m_used[p] = 1;
          break;
        end
      end
    end
    if (r.fail) m_any_fail = 1;
    m_widx++;
    if (last || m_widx == NWR) m_run = 0;
  endtask

  function automatic bit exp_recov_all();
    bit ok = 1;
    for (int e = 0; e < NFE; e++)
      if (m_mask[e] != '0 && !m_recov[e]) ok = 0;
    return ok;
  endfunction

  function automatic int exp_hit();
`ifdef WA_HIT_CNT_EN
    return (m_hits > NWR) ? NWR : m_hits;
`else
    return 0;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [AS*WW-1:0] w_zero_at(input logic [AS-1:0] zcols);
    logic [AS*WW-1:0] w;
    for (int j = 0; j < AS; j++) w[j*WW +: WW] = zcols[j] ? '0 : WW'(j + 1);
    return w;
  endfunction

  function automatic logic [AS*WW-1:0] rand_weight(input int zero_pct);
    logic [AS*WW-1:0] w;
    for (int j = 0; j < AS; j++)
      w[j*WW +: WW] = ($urandom_range(99) < zero_pct) ? '0 : WW'($urandom_range(255, 1));
    return w;
  endfunction

  function automatic logic [AS-1:0] rand_mask();
    logic [AS-1:0] m = '0;
    if ($urandom_range(3) == 0) return '0;
    repeat ($urandom_range(3, 1)) m[$urandom_range(AS - 1)] = 1'b1;
    return m;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_ready"},   w_ready,   0);
    check({tag, "_map_valid"}, map_valid, 0);
    check({tag, "_map_widx"},  map_widx,  0);
    check({tag, "_map_prow"},  map_prow,  0);
    check({tag, "_map_fhit"},  map_fhit,  0);
    check({tag, "_map_fail"},  map_fail,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_success"},   success,   0);
    check({tag, "_recov_all"}, recov_all, 0);
    check({tag, "_hit_cnt"},   hit_cnt,   0);
  endtask

  task automatic write_fault(input int idx, input int row, input logic [AS-1:0] mask);
    @(posedge clk); #1;
    flt_wr_en = 1'b1; flt_wr_idx = FE_AW'(idx); flt_wr_row = ROW_AW'(row); flt_wr_mask = mask;
    model_write(idx, row, mask);
    @(posedge clk); #1;
    flt_wr_en = 1'b0;
  endtask

  task automatic finish_run();
    @(posedge clk); #1;
    start = 1'b0; flt_wr_en = 1'b0; w_valid = 1'b0; w_last = 1'b0; map_ready = 1'b1;
    #1;
    check("drain_done", done, 0);
    check("drain_busy", busy, 1);
    check("drain_map_valid", map_valid, 0);
    @(posedge clk); #2;
    check("check_done", done, 0);
    @(posedge clk); #2;
    check("done_pulse", done, 1);
    check("success", success, !m_any_fail);
    check("recov_all", recov_all, exp_recov_all());
    check("hit_cnt", hit_cnt, exp_hit());
    d_success = success; d_recov = recov_all; d_hit = int'(hit_cnt);
    @(posedge clk); #2;
    check("done_clear", done, 0);
    check("idle_busy", busy, 0);
    check("success_hold", success, !m_any_fail);
    check("recov_all_hold", recov_all, exp_recov_all());
  endtask

  // Plays wq through the DUT, checking every cycle against the model.
  task automatic run_weights(input int rdy_pct, input int vld_pct, input bit use_last,
                             input int abort_after, input int hold, input bit noise,
                             input bit ws_en, input int ws_idx, input int ws_row,
                             input logic [AS-1:0] ws_mask);
    int   sent, accepts, cyc;
    bit   exp_rdy, hs, acc;
    rec_t r;
    sent = 0; accepts = 0; cyc = 0;
    got_q.delete(); exp_q.delete();
    hold_left = hold;
    @(posedge clk); #1;
    start = 1'b1;
    if (ws_en) begin
      flt_wr_en = 1'b1; flt_wr_idx = FE_AW'(ws_idx); flt_wr_row = ROW_AW'(ws_row); flt_wr_mask = ws_mask;
      model_write(ws_idx, ws_row, ws_mask);
    end
    model_start();
    forever begin
      @(posedge clk); #1;
      start       = noise ? 1'($urandom_range(1)) : 1'b0;
      flt_wr_en   = noise ? 1'($urandom_range(1)) : 1'b0;
      flt_wr_idx  = FE_AW'($urandom);
      flt_wr_row  = ROW_AW'($urandom);
      flt_wr_mask = AS'($urandom);
      w_valid = m_run && (sent < wq.size()) && ($urandom_range(99) < vld_pct);
      w_row   = w_valid ? wq[sent] : {$urandom, $urandom};
      w_last  = w_valid && use_last && (sent == wq.size() - 1);
      if (exp_q.size() != 0 && hold_left > 0) begin
        map_ready = 1'b0;
        hold_left--;
      end else begin
        map_ready = ($urandom_range(99) < rdy_pct);
      end
      #1;
      exp_rdy = m_run && (exp_q.size() == 0 || map_ready);
      check("busy_run", busy, 1);
      check("w_ready", w_ready, exp_rdy);
      check("map_valid", map_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("map_widx", map_widx, exp_q[0].widx);
        check("map_prow", map_prow, exp_q[0].prow);
        check("map_fhit", map_fhit, exp_q[0].fhit);
        check("map_fail", map_fail, exp_q[0].fail);
      end
      hs  = (exp_q.size() != 0) && map_ready;
      acc = w_valid && exp_rdy;
      if (hs) begin
        got_q.push_back('{int'(map_widx), int'(map_prow), map_fhit, map_fail});
        void'(exp_q.pop_front());
      end
      if (acc) begin
        model_accept(w_row, w_last, r);
        exp_q.push_back(r);
        sent++; accepts++;
      end
      cyc++;
      if (abort_after > 0 && accepts == abort_after) break;
      if (!m_run && exp_q.size() == 0) break;
      if (cyc > 400) begin
        check("run_timeout", 1, 0);
        break;
      end
    end
    if (abort_after == 0) finish_run();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");

    // Popcount priority, healthy fallback, second faulty match.
    write_fault(0, 2, 8'h05);
    write_fault(1, 5, 8'h10);
    wq.delete();
    wq.push_back(w_zero_at(8'h15));
    wq.push_back(w_zero_at(8'h00));
    wq.push_back(w_zero_at(8'h10));
    run_weights(100, 100, 1, 0, 0, 0, 0, 0, 0, '0);
    check("t1_count", got_q.size(), 3);
    if (got_q.size() >= 3) begin
      check("t1_prow0", got_q[0].prow, 2);
      check("t1_fhit0", got_q[0].fhit, 1);
      check("t1_prow1", got_q[1].prow, 0);
      check("t1_fhit1", got_q[1].fhit, 0);
      check("t1_prow2", got_q[2].prow, 5);
      check("t1_fhit2", got_q[2].fhit, 1);
    end
    check("t1_success", d_success, 1);
    check("t1_recov_all", d_recov, 1);
`ifdef WA_HIT_CNT_EN
    check("t1_hit_cnt", d_hit, 2);
`else
    check("t1_hit_cnt", d_hit, 0);
`endif

    // Healthy-row exhaustion; run ends on the row-count limit without w_last.
    write_fault(0, 1, 8'h01);
    write_fault(1, 3, 8'h02);
    write_fault(2, 5, 8'h04);
    write_fault(3, 7, 8'h08);
    wq.delete();
    repeat (NWR) wq.push_back(w_zero_at(8'h00));
    run_weights(100, 100, 0, 0, 0, 0, 0, 0, 0, '0);
    check("t2_count", got_q.size(), 8);
    if (got_q.size() >= 8) begin
      check("t2_prow3", got_q[3].prow, 6);
      check("t2_fail3", got_q[3].fail, 0);
      check("t2_fail4", got_q[4].fail, 1);
      check("t2_prow4", got_q[4].prow, 0);
      check("t2_fail7", got_q[7].fail, 1);
      check("t2_widx7", got_q[7].widx, 7);
    end
    check("t2_success", d_success, 0);
    check("t2_recov_all", d_recov, 0);

    // Output backpressure: consumer stalls for 5 cycles on the first record.
    write_fault(0, 2, 8'h05);
    write_fault(1, 5, 8'h10);
    write_fault(2, 0, 8'h00);
    write_fault(3, 0, 8'h00);
    wq.delete();
    repeat (4) wq.push_back(rand_weight(50));
    run_weights(100, 100, 1, 0, 5, 0, 0, 0, 0, '0);
    check("t3_count", got_q.size(), 4);

    // Reset in the middle of a run after two accepts.
    wq.delete();
    repeat (6) wq.push_back(rand_weight(50));
    run_weights(100, 100, 1, 2, 0, 0, 0, 0, 0, '0);
    @(posedge clk); #1;
    w_valid = 1'b0; w_last = 1'b0; start = 1'b0; flt_wr_en = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_reset_outputs("abort");
    model_reset();
    // Empty table after reset: all-nonzero rows land on rows 0,1,...
    wq.delete();
    repeat (2) wq.push_back(w_zero_at(8'h00));
    run_weights(100, 100, 1, 0, 0, 0, 0, 0, 0, '0);
    if (got_q.size() >= 2) check("t4_prow1", got_q[1].prow, 1);
    // Duplicate rows in the table.
    write_fault(0, 4, 8'h03);
    write_fault(1, 4, 8'h01);
    wq.delete();
    repeat (5) wq.push_back(rand_weight(60));
    run_weights(80, 90, 1, 0, 0, 0, 0, 0, 0, '0);

    // Randomized runs with busy-time write/start noise and start+write.
    for (int t = 0; t < 40; t++) begin
      int n;
      repeat ($urandom_range(3)) write_fault($urandom_range(NFE - 1), $urandom_range(AS - 1), rand_mask());
      n = $urandom_range(NWR, 1);
      wq.delete();
      repeat (n) wq.push_back(rand_weight($urandom_range(70, 20)));
      run_weights($urandom_range(100, 30), $urandom_range(100, 40),
                  (n < NWR) ? 1'b1 : 1'($urandom_range(1)), 0,
                  ($urandom_range(3) == 0) ? $urandom_range(4) : 0, 1,
                  ($urandom_range(2) == 0), $urandom_range(NFE - 1),
                  $urandom_range(AS - 1), rand_mask());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
